// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU: datapath width, opcodes, subops,
// register-load destination codes and phase indices.
package cpu_pkg;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NPHASE = 8;

    typedef logic [7:0] opcode_t;
    typedef logic [3:0] reg_load_t;

    // Opcodes decoded by the execution ALU
    localparam opcode_t OP_PUSH_EBP    = 8'h55;
    localparam opcode_t OP_POP_EBP     = 8'h5D;
    localparam opcode_t OP_RET         = 8'hC3;
    localparam opcode_t OP_MOV_RM      = 8'h89;
    localparam opcode_t OP_MOV_EAX_IMM = 8'hB8;
    localparam opcode_t OP_GRP83       = 8'h83;

    // ModRM subops of the 0x83 group that touch esp
    localparam opcode_t SUB_ESP = 8'hEC;
    localparam opcode_t ADD_ESP = 8'hC4;

    // Register-file / stack write-enable codes; RL_NONE means no write
    localparam reg_load_t RL_NONE  = 4'd0;
    localparam reg_load_t RL_EAX   = 4'd1;
    localparam reg_load_t RL_ESP   = 4'd2;
    localparam reg_load_t RL_EBP   = 4'd3;
    localparam reg_load_t RL_ECX   = 4'd4;
    localparam reg_load_t RL_STACK = 4'd5;
    localparam reg_load_t RL_PC    = 4'd6;
    localparam reg_load_t RL_EDX   = 4'd7;
    localparam reg_load_t RL_EBX   = 4'd8;
    localparam reg_load_t RL_ESI   = 4'd9;
    localparam reg_load_t RL_EDI   = 4'd10;

    // Phase bit positions within the one-hot ring
    localparam int unsigned PH_FETCH    = 0;
    localparam int unsigned PH_DECODE   = 1;
    localparam int unsigned PH_OPSEL    = 2;
    localparam int unsigned PH_STEP1    = 3;
    localparam int unsigned PH_STEP1_WB = 4;
    localparam int unsigned PH_STEP2    = 5;
    localparam int unsigned PH_STEP2_WB = 6;
    localparam int unsigned PH_LAST     = 7;

    typedef enum logic {
        StepOne,
        StepTwo
    } alu_step_e;

endpackage

// File: rtl/cpu_exec_phase_if.sv
// Bus between the operand selector / decoder and the execution phase core,
// plus the write-back outputs toward the register file.
interface cpu_exec_phase_if #(
    parameter int unsigned WIDTH = 32
);
    logic [31:0]      ope;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] operand;
    logic [3:0]       reg_load_1;
    logic [3:0]       reg_load_2;
    logic [7:0]       phase;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       selected_reg_load;

    modport master (
        output ope,
        output imm,
        output operand,
        output reg_load_1,
        output reg_load_2,
        input  phase,
        input  alu_result,
        input  selected_reg_load
    );

    modport slave (
        input  ope,
        input  imm,
        input  operand,
        input  reg_load_1,
        input  reg_load_2,
        output phase,
        output alu_result,
        output selected_reg_load
    );

endinterface

// File: rtl/cpu_phase_ring.sv
// One-hot phase sequencer: a single set bit rotates upward one position per clock.
module cpu_phase_ring #(
    parameter int unsigned NPHASE = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [NPHASE-1:0] phase
);

    logic [NPHASE-1:0] phase_q;
    logic [NPHASE-1:0] phase_d;

    always_comb begin
        phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= NPHASE'(1);
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/cpu_exec_phase.sv
// Execution-phase core: phase ring, two-step ALU and destination selector.
// ALU result and write-enable code are registered together so they stay aligned.
module cpu_exec_phase
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH  = cpu_pkg::WIDTH,
    parameter int unsigned NPHASE = cpu_pkg::NPHASE
) (
    input  logic          clk,
    input  logic          reset,
    cpu_exec_phase_if.slave bus
);

    logic [NPHASE-1:0] phase;
    logic              step1;
    logic              step2;
    logic [WIDTH-1:0]  alu_value;
    logic [WIDTH-1:0]  alu_result_q;
    logic [WIDTH-1:0]  alu_result_d;
    reg_load_t         sel_q;
    reg_load_t         sel_d;

    cpu_phase_ring #(
        .NPHASE(NPHASE)
    ) u_phase_ring (
        .clk  (clk),
        .reset(reset),
        .phase(phase)
    );

    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [31:0]      op_word,
        input logic [WIDTH-1:0] imm_v,
        input logic [WIDTH-1:0] operand_v,
        input alu_step_e        step
    );
        logic [WIDTH-1:0] imm8_z;
        logic [WIDTH-1:0] res;
        imm8_z = WIDTH'(op_word[15:8]);
        res    = operand_v;
        case (op_word[31:24])
            OP_PUSH_EBP: begin
                // Step 1 pre-decrements esp; step 2 stores the pushed value.
                res = (step == StepOne) ? operand_v - WIDTH'(4) : operand_v;
            end
            OP_POP_EBP, OP_RET: begin
                res = (step == StepOne) ? operand_v : operand_v + WIDTH'(4);
            end
            OP_MOV_RM:      res = operand_v;
            OP_MOV_EAX_IMM: res = imm_v;
            OP_GRP83: begin
                case (op_word[23:16])
                    SUB_ESP: res = operand_v - imm8_z;
                    ADD_ESP: res = operand_v + imm8_z;
                    default: res = operand_v;
                endcase
            end
            default: res = operand_v;
        endcase
        return res;
    endfunction

    assign step1 = phase[PH_STEP1];
    assign step2 = phase[PH_STEP2];

    always_comb begin
        alu_value = alu_eval(bus.ope, bus.imm, bus.operand, step2 ? StepTwo : StepOne);
    end

    always_comb begin
        alu_result_d = alu_result_q;
        sel_d        = RL_NONE;
        if (step1) begin
            alu_result_d = alu_value;
            sel_d        = bus.reg_load_1;
        end else if (step2) begin
            alu_result_d = alu_value;
            sel_d        = bus.reg_load_2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_q <= '0;
            sel_q        <= RL_NONE;
        end else begin
            alu_result_q <= alu_result_d;
            sel_q        <= sel_d;
        end
    end

    assign bus.phase             = phase;
    assign bus.alu_result        = alu_result_q;
    assign bus.selected_reg_load = sel_q;

    // Low immediate byte is consumed by the decoder, not by this block.
    logic unused_ope;
    assign unused_ope = ^bus.ope[7:0];

endmodule

// File: tb/tb_cpu_exec_phase.sv
// Self-checking bench for cpu_exec_phase: directed cases plus random instructions
// checked each cycle against an instruction-level reference model.
module tb_cpu_exec_phase;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_alu;

    cpu_exec_phase_if #(.WIDTH(32)) bus ();

    cpu_exec_phase dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Write-back value of one instruction step, straight from the opcode table.
    function automatic logic [31:0] model(input logic [31:0] o, input logic [31:0] im,
                                          input logic [31:0] opd, input int step);
        logic [31:0] imm8;
        imm8 = {24'd0, o[15:8]};
        if (o[31:24] == 8'h55) return (step == 1) ? opd - 32'd4 : opd;
        if (o[31:24] == 8'h5D || o[31:24] == 8'hC3) return (step == 1) ? opd : opd + 32'd4;
        if (o[31:24] == 8'hB8) return im;
        if (o[31:24] == 8'h83 && o[23:16] == 8'hEC) return opd - imm8;
        if (o[31:24] == 8'h83 && o[23:16] == 8'hC4) return opd + imm8;
        return opd;
    endfunction

    // Called at a negedge with phase at clock_1; leaves at the next clock_1 negedge.
    task automatic run_instr(input string tag, input logic [31:0] o, input logic [31:0] im,
                             input logic [31:0] opd, input logic [3:0] rl1,
                             input logic [3:0] rl2, input int stop_at);
        logic [3:0] exp_sel;
        bus.ope        = o;
        bus.imm        = im;
        bus.operand    = opd;
        bus.reg_load_1 = rl1;
        bus.reg_load_2 = rl2;
        for (int k = 0; k < 8; k++) begin
            exp_sel = 4'd0;
            if (k == 4) begin
                exp_alu = model(o, im, opd, 1);
                exp_sel = rl1;
            end
            if (k == 6) begin
                exp_alu = model(o, im, opd, 2);
                exp_sel = rl2;
            end
            check({tag, ".phase"}, {24'd0, bus.phase}, 32'd1 << k);
            check({tag, ".alu"}, bus.alu_result, exp_alu);
            check({tag, ".sel"}, {28'd0, bus.selected_reg_load}, {28'd0, exp_sel});
            if (k == stop_at) return;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0]  ops [8];
        logic [31:0] o;
        logic [7:0]  modrm;
        n_checks = 0;
        n_fail   = 0;
        exp_alu  = 32'd0;
        ops[0] = 8'h55; ops[1] = 8'h5D; ops[2] = 8'hC3; ops[3] = 8'h89;
        ops[4] = 8'hB8; ops[5] = 8'h83; ops[6] = 8'h83; ops[7] = 8'h00;
        bus.ope = '0; bus.imm = '0; bus.operand = '0;
        bus.reg_load_1 = '0; bus.reg_load_2 = '0;

        // Reset held for two cycles; outputs must stay cleared.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst.phase", {24'd0, bus.phase}, 32'h01);
            check("rst.alu", bus.alu_result, 32'd0);
            check("rst.sel", {28'd0, bus.selected_reg_load}, 32'd0);
        end
        reset = 1'b1;

        run_instr("push", 32'h5500_0000, 32'd0, 32'h0000_1000, 4'd2, 4'd5, 8);
        run_instr("subesp", 32'h83EC_1000, 32'd0, 32'h0000_0100, 4'd2, 4'd0, 8);
        run_instr("addesp", 32'h83C4_0800, 32'd0, 32'h0000_0100, 4'd2, 4'd0, 8);
        run_instr("movimm", 32'hB802_0000, 32'h0000_0002, 32'hDEAD_BEEF, 4'd1, 4'd1, 8);
        run_instr("wrap", 32'h5500_0000, 32'd0, 32'h0000_0002, 4'd2, 4'd5, 8);
        run_instr("pop", 32'h5D00_0000, 32'd0, 32'hFFFF_FFFC, 4'd3, 4'd2, 8);
        run_instr("ret", 32'hC300_0000, 32'd0, 32'h0000_2000, 4'd6, 4'd2, 8);

        // Reset pulled while phase[5] is high; partial instruction is discarded.
        run_instr("midrst", 32'h5500_0000, 32'd0, 32'h0000_4000, 4'd2, 4'd5, 5);
        reset = 1'b0;
        #1;
        exp_alu = 32'd0;
        check("midrst.phase", {24'd0, bus.phase}, 32'h01);
        check("midrst.alu", bus.alu_result, 32'd0);
        check("midrst.sel", {28'd0, bus.selected_reg_load}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_instr("restart", 32'h8900_0000, 32'd0, 32'h1234_5678, 4'd1, 4'd7, 8);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       modrm = 8'hEC;
                1:       modrm = 8'hC4;
                default: modrm = 8'($urandom);
            endcase
            o = {ops[$urandom_range(0, 7)], modrm, 8'($urandom), 8'($urandom)};
            if (n % 8 == 7) o[31:24] = 8'($urandom);
            run_instr("rand", o, $urandom, $urandom, 4'($urandom_range(1, 15)),
                      4'($urandom_range(1, 15)), 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_exec_phase.md
# cpu_exec_phase

Execution-phase core of the multi-cycle CPU. It combines three functions:

- **Phase generator:** an 8-phase one-hot sequencer that drives fetch, decode, operand select and register write-back.
- **Two-step ALU:** computes the write-back value for each instruction step.
- **Destination selector:** routes the decoder's per-step register-load code onto a single write-enable bus.

It sits between the operand selector and the register file / stack memory.

## Interface
Parameters:
- `WIDTH`, 32, datapath width.
- `NPHASE`, 8, phases per instruction (fixed at 8; not meant to be changed).

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `ope` in 32: current instruction word; opcode in `ope[31:24]`, ModRM/subop in `ope[23:16]`, imm8 in `ope[15:8]`.
- `imm` in 32: 32-bit immediate operand.
- `operand` in 32: selected register/stack value from the operand selector.
- `reg_load_1` in 4: destination code for step 1.
- `reg_load_2` in 4: destination code for step 2.
- `phase` out 8: one-hot phase strobes; bit0 = clock_1 … bit7 = clock_8.
- `alu_result` out 32: ALU result bus.
- `selected_reg_load` out 4: destination code currently being written; 0 = none.

## Operation
**Phase ring**
- Exactly one `phase` bit is high at any time.
- Rotates bit0→bit7→bit0, advancing one bit per `clk` rising edge.
- Each instruction therefore takes 8 cycles.

**ALU**
- Evaluates on the edge at which `phase[3]` (step 1) or `phase[5]` (step 2) is high.
- Result, by `ope[31:24]`:
  - `0x55` push: step 1 `operand-4`; step 2 `operand`.
  - `0x5D` pop: step 1 `operand`; step 2 `operand+4`.
  - `0xC3` ret: step 1 `operand`; step 2 `operand+4`.
  - `0x89` mov: `operand` in both steps.
  - `0xB8` mov eax,imm: `imm` in both steps.
  - `0x83` with `ope[23:16]=0xEC` (sub esp): `operand - zext(ope[15:8])`; with `0xC4` (add esp): `operand + zext(ope[15:8])`; other subops: `operand`.
  - Any other opcode: `operand` (pass-through).
- Arithmetic is modulo 2^32; no flags, no overflow detection.

**Result selector**
- On the step-1 edge, `selected_reg_load` ← `reg_load_1`.
- On the step-2 edge, `selected_reg_load` ← `reg_load_2`.
- On every other edge, `selected_reg_load` ← 0.

## Timing
- **Reset** (`reset`=0, asynchronous): `phase`=8'b0000_0001, `alu_result`=0, `selected_reg_load`=0.
- **First edge after reset release:** `phase` goes to 8'b0000_0010.
- **Input sampling:** all inputs are sampled on `clk` rising edges only.
  - `ope`, `imm`, `operand` and `reg_load_*` must be stable on the phase[3] and phase[5] edges.
- **Output latency:** `alu_result` and `selected_reg_load` are registered with 1-cycle latency.
  - Step 1 is valid while `phase[4]` is high; step 2 while `phase[6]` is high.
  - `selected_reg_load` is nonzero for exactly one cycle per step.
- **Hold:** `alu_result` holds its last value until the next step edge.
- **Reset mid-instruction:** outputs clear immediately; the sequence restarts at phase 1; the partial instruction is discarded.
- **Data/enable alignment:** write data and write enable are aligned, so downstream registers load `alu_result` on the edge where `selected_reg_load` matches their code.

## Structure
- **Shared package `cpu_pkg`:**
  - `WIDTH`.
  - Opcode constants `OP_PUSH_EBP`, `OP_POP_EBP`, `OP_RET`, `OP_MOV_RM`, `OP_MOV_EAX_IMM`, `OP_GRP83`.
  - Subop constants `SUB_ESP`, `ADD_ESP`.
  - Register-load codes: `RL_NONE`=0, plus the codes used by the register file.
  - Phase index constants.
- **Sub-module `cpu_phase_ring`:** the one-hot ring counter with async active-low reset.
- **Top level:** ALU and selector logic live in the top; the ALU function is a combinational function feeding the result register.

## Test plan
- **Reset and rotation:** assert `reset`=0 for 2 cycles, then release → `phase` reads 01, 02, 04 … 80, 01 on consecutive cycles; outputs are 0 during reset.
- **Push:** `ope`=0x55000000, `operand`=0x00001000, `reg_load_1`=2, `reg_load_2`=5 → phase[4] cycle: `alu_result`=0x00000FFC, `selected_reg_load`=2; phase[6] cycle: `alu_result`=0x00001000, `selected_reg_load`=5; all other cycles `selected_reg_load`=0.
- **Sub esp:** `ope`=0x83EC1000, `operand`=0x00000100 → `alu_result`=0x000000F0 at step 1.
- **Mov immediate:** `ope`=0xB8020000, `imm`=0x00000002 → `alu_result`=0x00000002 at both steps.
- **Wrap-around:** `ope`=0x55000000, `operand`=0x00000002 → step 1 result 0xFFFFFFFE.
- **Reset mid-instruction:** pull `reset` low while `phase[5]` is high → `phase`=01 and `alu_result`=0 immediately; after release the sequence restarts cleanly.
